// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: writeback request bus plus register-file write port.
interface regfile_wport_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [NREQ-1:0] req_val;
  logic [NREQ-1:0] req_rdy;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic init_done;
  modport master (output req_val, req_addr, req_data, input req_rdy, wen, waddr, wdata, init_done);
  modport slave (input req_val, req_addr, req_data, output req_rdy, wen, waddr, wdata, init_done);
endinterface

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: clears x1..x(2^AW-1) after reset, then round-robins the write port.
module regfile_wport_arbiter #(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst_n,
  regfile_wport_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  state_t state, state_d;
  logic [AW-1:0] clr_ptr;
  logic [PW-1:0] rr_ptr, g, cand;
  logic found, xfer;
  always_comb begin
    found = 1'b0;
    g = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_val[cand]) begin
        found = 1'b1;
        g = cand;
      end
    end
  end
  // outputs decode only from registered state and req_val, so reset forces IDLE values at once
  always_comb begin
    state_d = (state == IDLE) ? INIT : (state == INIT && &clr_ptr) ? RUN : state;
    xfer = (state == RUN) && found;
    bus.req_rdy = xfer ? NREQ'(1) << g : '0;
    bus.wen = (state == INIT) || (xfer && |bus.req_addr[g*AW +: AW]);
    bus.waddr = (state == INIT) ? clr_ptr : xfer ? bus.req_addr[g*AW +: AW] : '0;
    bus.wdata = xfer ? bus.req_data[g*DW +: DW] : '0;
    bus.init_done = (state == RUN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clr_ptr <= AW'(1);
      rr_ptr <= '0;
    end else begin
      state <= state_d;
      if (state == INIT && !(&clr_ptr)) clr_ptr <= clr_ptr + 1'b1;
      if (xfer) rr_ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed scoreboard bench for the write-port arbiter.
module tb_regfile_wport_arbiter;
  logic clk, rst_n;
  int n_cmp = 0, n_err = 0;
  regfile_wport_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();
  regfile_wport_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // downstream register file; x0 is deliberately writable so a stray wen to x0 shows up
  logic [31:0] rf [32] = '{0: 32'h0, default: 32'hBAD0BAD0};
  always @(posedge clk) if (bus.wen) rf[bus.waddr] <= bus.wdata;
  typedef struct {string tag; logic [41:0] v;} exp_t;
  exp_t sb[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [2:0] rdy, input logic w, input logic [4:0] a, input logic [31:0] d, input logic dn);
    sb.push_back('{tag, {rdy, w, a, d, dn}});
  endtask
  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, {22'd0, bus.req_rdy, bus.wen, bus.waddr, bus.wdata, bus.init_done}, {22'd0, e.v});
  endtask
  task automatic step(input string tag, input logic [2:0] rdy, input logic w, input logic [4:0] a, input logic [31:0] d, input logic dn);
    push(tag, rdy, w, a, d, dn);
    #1 pop_check();
    @(negedge clk);
  endtask
  task automatic set_req(input logic [2:0] v, input logic [4:0] a0, a1, a2, input logic [31:0] d0, d1, d2);
    bus.req_val = v;
    bus.req_addr = {a2, a1, a0};
    bus.req_data = {d2, d1, d0};
  endtask
  initial begin
    rst_n = 1'b0;
    set_req(3'b111, 5'd7, 5'd8, 5'd9, 32'hA0, 32'hA1, 32'hA2);
    @(negedge clk);
    step("in_reset", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    step("idle_c0", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 31; k++) step($sformatf("init_c%0d", k), 3'b000, 1'b1, 5'(k), 32'd0, 1'b0);
    for (int r = 1; r <= 31; r++) cmp($sformatf("clr_x%0d", r), 64'(rf[r]), 64'd0);
    step("run_first_g0", 3'b001, 1'b1, 5'd7, 32'hA0, 1'b1);
    set_req(3'b010, 5'd7, 5'd5, 5'd9, 32'hA0, 32'hDEADBEEF, 32'hA2);
    step("single_g1", 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    set_req(3'b111, 5'd7, 5'd8, 5'd9, 32'hA0, 32'hA1, 32'hA2);
    step("rr_after1_g2", 3'b100, 1'b1, 5'd9, 32'hA2, 1'b1);
    cmp("x5", 64'(rf[5]), 64'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      set_req(3'b111, 5'd11, 5'd12, 5'd13, 32'h3000_0000 + 32'(i*3), 32'h3000_0001 + 32'(i*3), 32'h3000_0002 + 32'(i*3));
      step($sformatf("fair_%0d", i), 3'(1 << (i % 3)), 1'b1, 5'(11 + i % 3), 32'h3000_0000 + 32'(i*3 + i % 3), 1'b1);
    end
    set_req(3'b010, 5'd0, 5'd14, 5'd0, 32'd0, 32'h4000_0001, 32'd0);
    step("skip_g1", 3'b010, 1'b1, 5'd14, 32'h4000_0001, 1'b1);
    set_req(3'b000, 5'd3, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3);
    step("skip_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    set_req(3'b101, 5'd16, 5'd0, 5'd15, 32'h5000_0000, 32'd0, 32'h5000_0002);
    step("skip_g2", 3'b100, 1'b1, 5'd15, 32'h5000_0002, 1'b1);
    step("skip_g0", 3'b001, 1'b1, 5'd16, 32'h5000_0000, 1'b1);
    set_req(3'b001, 5'd0, 5'd0, 5'd0, 32'h12345678, 32'd0, 32'd0);
    step("x0_g0", 3'b001, 1'b0, 5'd0, 32'h12345678, 1'b1);
    set_req(3'b111, 5'd20, 5'd21, 5'd22, 32'h60, 32'h61, 32'h62);
    step("x0_rr_g1", 3'b010, 1'b1, 5'd21, 32'h61, 1'b1);
    cmp("x0_zero", 64'(rf[0]), 64'd0);
    cmp("x15", 64'(rf[15]), 64'h5000_0002);
    rst_n = 1'b0;
    step("rst2", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    step("rst2_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 9; k++) step($sformatf("init2_c%0d", k), 3'b000, 1'b1, 5'(k), 32'd0, 1'b0);
    push("init2_c10", 3'b000, 1'b1, 5'd10, 32'd0, 1'b0);
    #1 pop_check();
    #1 rst_n = 1'b0;
    push("mid_rst", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step("re_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 31; k++) step($sformatf("init3_c%0d", k), 3'b000, 1'b1, 5'(k), 32'd0, 1'b0);
    step("re_run_g0", 3'b001, 1'b1, 5'd20, 32'h60, 1'b1);
    cmp("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
